// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings,
// default halt marker and idle timeout, and the byte width used when
// assembling little-endian instruction words from the UART FIFO.
package instruction_loader_pkg;

  // Width of one received byte.
  localparam int BYTE_SIZE = 8;

  // Defaults for the loader configuration.
  localparam int          DEFAULT_WORD_SIZE_IN_BYTES = 4;
  localparam logic [31:0] DEFAULT_HALT_WORD          = 32'hFFFF_FFFF;
  localparam int          DEFAULT_TIMEOUT_CYCLES     = 1_000_000;

  // Loader FSM states, 3-bit encoded.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RECV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  // The loader owns the memory interface while clearing, receiving or writing.
  function automatic logic state_is_busy(input state_t s);
    return (s == ST_CLEAR) || (s == ST_RECV) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// word_assembler: byte counter plus insert buffer that builds one
// little-endian word. The first loaded byte lands in bits [7:0].
// o_word presents the buffer including the byte being loaded this
// cycle, so the caller can capture a complete word on the same edge
// that o_last is high.
module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_clr,
  input  logic                                    i_load,
  input  logic [BYTE_SIZE-1:0]                    i_byte,
  output logic [BYTE_SIZE*WORD_SIZE_IN_BYTES-1:0] o_word,
  output logic                                    o_last,
  output logic                                    o_partial
);

  localparam int WORD_W = BYTE_SIZE * WORD_SIZE_IN_BYTES;
  localparam int CNT_W  = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_SIZE_IN_BYTES - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] buf_q, buf_d;

  assign o_last    = i_load && !i_clr && (cnt_q == LAST_IDX);
  assign o_partial = (cnt_q != '0);
  assign o_word    = buf_d;

  // Insert the incoming byte at the current slot and advance the counter,
  // wrapping to zero after the last byte of the word.
  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      buf_d[BYTE_SIZE*cnt_q +: BYTE_SIZE] = i_byte;
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Byte counter is control state and is reset; a reset discards any partial word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Word buffer is pure data; stale contents are always overwritten before use.
  always_ff @(posedge i_clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: pulls bytes from the debug UART receive FIFO,
// assembles them into little-endian instruction words and writes them
// sequentially into instruction memory, stopping after the HALT word.
// Optional feature macro: INSTRUCTION_LOADER_TIMEOUT_EN adds an idle
// counter that aborts to ERROR when a partial word stalls for
// TIMEOUT_CYCLES cycles. Without it a partial word waits indefinitely.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int                                    WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES,
  parameter logic [BYTE_SIZE*WORD_SIZE_IN_BYTES-1:0] HALT_WORD        = DEFAULT_HALT_WORD,
  parameter int                                    TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_start,
  input  logic [BYTE_SIZE-1:0]                    i_rx_data,
  input  logic                                    i_rx_empty,
  input  logic                                    i_mem_full,
  output logic                                    o_rx_read,
  output logic                                    o_clear,
  output logic                                    o_instruction_write,
  output logic [BYTE_SIZE*WORD_SIZE_IN_BYTES-1:0] o_instruction,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic                                    o_error
);

  localparam int WORD_W = BYTE_SIZE * WORD_SIZE_IN_BYTES;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] instruction_q, instruction_d;
  logic              clear_q, clear_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              asm_load;
  logic              asm_clr;
  logic [WORD_W-1:0] asm_word;
  logic              asm_last;
  logic              asm_partial;
  logic              timeout_hit;

  // Pop only in RECV with data present; the reset cycle never pops or writes.
  assign o_rx_read           = (state_q == ST_RECV) && !i_rx_empty && !i_reset;
  assign o_instruction_write = (state_q == ST_WRITE) && !i_mem_full && !i_reset;
  assign o_instruction       = instruction_q;
  assign o_clear             = clear_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_error             = error_q;

  assign asm_load = o_rx_read;
  assign asm_clr  = (state_q == ST_CLEAR);

  word_assembler #(
    .WORD_SIZE_IN_BYTES (WORD_SIZE_IN_BYTES)
  ) u_word_assembler (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (asm_clr),
    .i_load    (asm_load),
    .i_byte    (i_rx_data),
    .o_word    (asm_word),
    .o_last    (asm_last),
    .o_partial (asm_partial)
  );

`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // Count stalled cycles inside a partial word; any pop or leaving RECV restarts it.
  always_comb begin
    idle_d      = '0;
    timeout_hit = 1'b0;
    if ((state_q == ST_RECV) && asm_partial && i_rx_empty) begin
      timeout_hit = (idle_q == IDLE_LAST);
      idle_d      = idle_q + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = asm_partial ^ (TIMEOUT_CYCLES != 0);
`endif

  // Next-state logic; status outputs are decoded from the next state so they
  // are registered and line up with the state they describe.
  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_RECV;
      end
      ST_RECV: begin
        if (asm_last) begin
          state_d       = ST_WRITE;
          instruction_d = asm_word;
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITE: begin
        if (i_mem_full) begin
          state_d = ST_ERROR;
        end else if (instruction_q == HALT_WORD) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (i_start) state_d = ST_CLEAR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    clear_d = (state_d == ST_CLEAR);
    busy_d  = state_is_busy(state_d);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  // Loader FSM and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      instruction_q <= '0;
      clear_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      clear_q       <= clear_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program loader for the instruction fetch stage. It pulls bytes from the debug UART receive FIFO and assembles them little-endian into 32-bit instruction words. Each word is written sequentially into the instruction memory through its write port, and the loader stops after the HALT word has been written. It sits directly upstream of the instruction memory and drives that block's clear, write and data inputs.

## Interface
- WORD_SIZE_IN_BYTES, 4: bytes per instruction word.
- HALT_WORD, 32'hFFFF_FFFF: end-of-program marker. It is written to memory, then loading stops.
- TIMEOUT_CYCLES, 1_000_000: maximum idle gap inside a partial word. Used only with INSTRUCTION_LOADER_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to begin a load. Honoured in IDLE, DONE and ERROR.
- i_rx_data  in  8  head byte of the UART receive FIFO (first-word-fall-through).
- i_rx_empty  in  1  receive FIFO empty.
- i_mem_full  in  1  instruction memory full flag.
- o_rx_read  out  1  FIFO pop. Combinational: high in RECV when i_rx_empty is low.
- o_clear  out  1  one-cycle clear pulse to the instruction memory.
- o_instruction_write  out  1  one-cycle write strobe.
- o_instruction  out  32  assembled word, registered.
- o_busy  out  1  high in CLEAR, RECV and WRITE.
- o_done  out  1  high in DONE.
- o_error  out  1  high in ERROR.

## Operation
- States and transitions:
  - IDLE: waits for i_start, then goes to CLEAR.
  - CLEAR: asserts o_clear for one cycle, then goes to RECV. The byte counter clears to 0.
  - RECV: each cycle with i_rx_empty=0, pops one byte and stores it at bits [8*cnt +: 8] of the word buffer; cnt increments. When the byte with cnt=3 is popped, the state goes to WRITE.
  - WRITE: if i_mem_full=1, goes to ERROR with no write. Otherwise pulses o_instruction_write with o_instruction holding the buffer, then goes to DONE if the word equals HALT_WORD, else to RECV.
  - DONE and ERROR: held until i_start (restart goes to CLEAR) or reset.
- Byte order: the first received byte is bits [7:0]; the fourth received byte is bits [31:24].
- i_start is ignored while o_busy=1.
- Bytes present in the FIFO are never popped outside RECV.
- Reset mid-load: the state returns to IDLE and the partial word is discarded. No clear or write pulse is issued on the reset cycle.
- Reset values: state IDLE; o_instruction 0; cnt 0. o_clear, o_instruction_write, o_busy, o_done, o_error and o_rx_read are all 0.

## Timing
- From i_start to o_clear: 1 cycle.
- The first pop occurs no earlier than the cycle after o_clear.
- From the 4th byte popped to o_instruction_write: 1 cycle.
- The next pop occurs no earlier than the cycle after the write.
- Peak throughput: one word per 5 cycles.
- o_instruction is stable from the write cycle until the next write.
- The memory write pointer advances on the write edge. i_mem_full is sampled in WRITE, so a memory of N words accepts exactly N writes.
- o_done or o_error asserts in the cycle after WRITE.

## Configuration
- INSTRUCTION_LOADER_TIMEOUT_EN defined:
  - An idle counter runs in RECV while cnt≠0 and i_rx_empty=1.
  - The counter resets on every pop.
  - Reaching TIMEOUT_CYCLES goes to ERROR.
- Not defined: no counter. A partial word waits indefinitely.

## Structure
- The shared header instruction_loader.vh holds:
  - the state encodings (3-bit localparams);
  - the default HALT_WORD and TIMEOUT_CYCLES;
  - the existing BYTE_SIZE and CLEAR macros.
- Natural sub-module: word_assembler.
  - Holds the byte counter and shift/insert buffer.
  - Ports: load, byte, clr, word, last.
  - The FSM stays in instruction_loader.

## Test plan
- **Normal load:** i_start, then bytes 13 00 00 20 and FF FF FF FF. Required:
  - one o_clear;
  - writes of 32'h2000_0013 then 32'hFFFF_FFFF;
  - o_done=1.
- **Gapped bytes:** FIFO empty for 7 cycles between the 2nd and 3rd byte. Required: the same word is written, with no extra pops.
- **Overflow:** i_mem_full=1 when the 5th word completes. Required: no 5th write, o_error=1, and the FIFO is not popped afterwards.
- **Reset mid-load:** reset after 2 bytes, then a fresh i_start with 4 bytes AA BB CC DD. Required: write of 32'hDDCC_BBAA.
- **Restart from DONE:** after o_done, i_start. Required: a new o_clear pulse one cycle later, and i_start during RECV is ignored.
- **INSTRUCTION_LOADER_TIMEOUT_EN:** TIMEOUT_CYCLES=16, one byte sent, then 16 idle cycles. Required: o_error=1. A full word sent with gaps under 16 cycles does not time out.
